// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Two-requester front end for a single-port (RW) SRAM macro. After reset the
// controller can zero-fill the whole array (one write per cycle), then it
// arbitrates the two requesters round-robin, one operation per cycle.
// All macro-facing outputs are registered. Read data is captured from the
// macro two cycles after acceptance and returned on a shared bus with a
// per-requester valid pulse.
//
// Parameters
//   ADDR_WIDTH      SRAM word address width
//   DATA_WIDTH      SRAM word width
//   NUM_WMASKS      byte-lane write-mask width (DATA_WIDTH/8)
//   CLEAR_ON_RESET  1: zero-fill all 2^ADDR_WIDTH words after reset
//
// Ports
//   clk0                 clock (also clocks the macro)
//   rst_n                synchronous active-low reset
//   req_valid/req_ready  per-requester handshake, bit i = requester i
//   req_we/req_wmask/req_addr/req_wdata  per-requester command fields
//   rsp_valid            one-cycle read-data-valid pulse per requester
//   rsp_rdata            shared read data, qualified by rsp_valid
//   init_done            high once requests are being accepted
//   csb0/web0/wmask0/addr0/din0 (out), dout0 (in)  macro RW port
//
// Build option
//   SRAM_ARB_PERF_EN  when defined, adds 16-bit saturating counters
//                     grant_cnt0, grant_cnt1 and conflict_cnt.
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WMASKS     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk0,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*NUM_WMASKS-1:0] req_wmask,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic                    csb0,
    output logic                    web0,
    output logic [NUM_WMASKS-1:0]   wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [15:0]             grant_cnt0,
    output logic [15:0]             grant_cnt1,
    output logic [15:0]             conflict_cnt
`endif
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_cnt, w_init_cnt_nxt;
    logic                    r_init_done;
    logic                    r_last_grant;

    logic                    w_grant_any;
    logic                    w_grant_id;
    logic [1:0]              w_ready;

    logic                    w_sel_we;
    logic [NUM_WMASKS-1:0]   w_sel_wmask;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    logic                    r_csb, r_web;
    logic [NUM_WMASKS-1:0]   r_wmask;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_din;

    logic                    r_vld_p1, r_src_p1;
    logic                    r_vld_p2, r_src_p2;
    logic [1:0]              r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    // State register
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
        end
    end

    // Next state and round-robin grant. Grants are withheld until init_done
    // so that, without the zero-fill, the first cycle after reset is idle.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_grant_any    = 1'b0;
        w_grant_id     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_cnt_nxt = r_init_cnt + CNT_ONE;
                if (r_init_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_init_done) begin
                    w_grant_any = |req_valid;
                    // On a tie, the requester not granted last time wins.
                    w_grant_id  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        w_ready = w_grant_any ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
    end

    assign req_ready   = w_ready;

    assign w_sel_we    = w_grant_id ? req_we[1] : req_we[0];
    assign w_sel_wmask = w_grant_id ? req_wmask[2*NUM_WMASKS-1:NUM_WMASKS]
                                    : req_wmask[NUM_WMASKS-1:0];
    assign w_sel_addr  = w_grant_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : req_addr[ADDR_WIDTH-1:0];
    assign w_sel_wdata = w_grant_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : req_wdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_id;
        end
    end

    // Stage p0 -> p1: register the macro command (presented during T..T+1)
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else if (r_state == ST_INIT) begin
            r_csb   <= 1'b0;
            r_web   <= 1'b0;
            r_wmask <= '1;
            r_addr  <= r_init_cnt;
            r_din   <= '0;
        end else if (w_grant_any) begin
            r_csb   <= 1'b0;
            r_web   <= ~w_sel_we;
            r_wmask <= w_sel_we ? w_sel_wmask : '0;
            r_addr  <= w_sel_addr;
            r_din   <= w_sel_we ? w_sel_wdata : '0;
        end else begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end
    end

    assign csb0   = r_csb;
    assign web0   = r_web;
    assign wmask0 = r_wmask;
    assign addr0  = r_addr;
    assign din0   = r_din;

    // Stage p1 -> p2: read tag follows the macro access (macro samples at T+1)
    // Stage p2 -> rsp: macro data is valid, capture it at T+2
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_src_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_src_p2    <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
        end else begin
            r_vld_p1    <= w_grant_any & ~w_sel_we;
            r_src_p1    <= w_grant_id;
            r_vld_p2    <= r_vld_p1;
            r_src_p2    <= r_src_p1;
            r_rsp_valid <= r_vld_p2 ? (r_src_p2 ? 2'b10 : 2'b01) : 2'b00;
            if (r_vld_p2) begin
                r_rsp_rdata <= dout0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign init_done = r_init_done;

`ifdef SRAM_ARB_PERF_EN
    logic [15:0] r_grant_cnt0, r_grant_cnt1, r_conflict_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            r_grant_cnt0   <= '0;
            r_grant_cnt1   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_grant_any && !w_grant_id) r_grant_cnt0 <= sat_inc(r_grant_cnt0);
            if (w_grant_any &&  w_grant_id) r_grant_cnt1 <= sat_inc(r_grant_cnt1);
            if ((r_state == ST_RUN) && r_init_done && (req_valid == 2'b11)) begin
                r_conflict_cnt <= sat_inc(r_conflict_cnt);
            end
        end
    end

    assign grant_cnt0   = r_grant_cnt0;
    assign grant_cnt1   = r_grant_cnt1;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Bench for sram_port_arbiter with a behavioural SRAM macro and a
// transaction-level reference model: a word array updated in acceptance
// order, a queue of expected read responses, and the round-robin rule.
// Build with SRAM_ARB_PERF_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int NM    = 4;
    localparam int DEPTH = 1 << AW;

    logic              clk0 = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [2*NM-1:0]   req_wmask;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              init_done;
    logic              csb0, web0;
    logic [NM-1:0]     wmask0;
    logic [AW-1:0]     addr0;
    logic [DW-1:0]     din0;
    logic [DW-1:0]     dout0;
`ifdef SRAM_ARB_PERF_EN
    logic [15:0]       grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    always #5 clk0 = ~clk0;

    sram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM), .CLEAR_ON_RESET(1)
    ) dut (
        .clk0(clk0), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0)
`ifdef SRAM_ARB_PERF_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
    );

    // Behavioural single-port macro: samples on posedge, read data after edge.
    // Contents start random so the zero-fill is observable.
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] mac_w;
    bit            seeded = 1'b0;
    always @(posedge clk0) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= $urandom;
            seeded <= 1'b1;
        end else if (csb0 === 1'b0) begin
            if (web0 === 1'b0) begin
                mac_w = sram[addr0];
                for (int b = 0; b < NM; b++)
                    if (wmask0[b]) mac_w[b*8 +: 8] = din0[b*8 +: 8];
                sram[addr0] <= mac_w;
            end else begin
                dout0 <= sram[addr0];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            src;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            cyc = 0;
    bit            m_known = 1'b0;
    bit            m_run = 1'b0;
    int            m_init_idx = 0;
    bit            m_last = 1'b1;
    bit            m_rst_chk = 1'b0;
    int            m_g0 = 0, m_g1 = 0, m_conf = 0;
    logic          e_csb, e_web;
    logic [NM-1:0] e_wmask;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    bit            e_din_chk;
    logic [DW-1:0] last_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_ready();
        if (!m_run || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b01) return 2'b01;
        if (req_valid == 2'b10) return 2'b10;
        return m_last ? 2'b01 : 2'b10;
    endfunction

    task automatic model_edge(input logic [1:0] er);
        bit            s;
        logic [AW-1:0] a;
        logic [NM-1:0] m;
        logic [DW-1:0] d;
        cyc++;
        m_known = 1'b1;
        e_csb = 1'b1; e_web = 1'b1; e_wmask = '0; e_addr = '0; e_din = '0; e_din_chk = 1'b1;
        if (!rst_n) begin
            rq.delete();
            m_run = 1'b0; m_init_idx = 0; m_last = 1'b1; m_rst_chk = 1'b1;
            m_g0 = 0; m_g1 = 0; m_conf = 0;
            return;
        end
        if (m_run && req_valid == 2'b11) m_conf++;
        if (!m_run) begin
            e_csb = 1'b0; e_web = 1'b0; e_wmask = '1; e_addr = AW'(m_init_idx);
            ref_mem[m_init_idx] = '0;
            m_init_idx++;
            if (m_init_idx == DEPTH) m_run = 1'b1;
        end else if (er != 2'b00) begin
            s = er[1];
            m_last = s;
            if (s) m_g1++; else m_g0++;
            a = req_addr[s*AW +: AW];
            m = req_wmask[s*NM +: NM];
            d = req_wdata[s*DW +: DW];
            e_csb = 1'b0; e_addr = a;
            if (req_we[s]) begin
                for (int b = 0; b < NM; b++)
                    if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
                e_web = 1'b0; e_wmask = m; e_din = d;
            end else begin
                e_din_chk = 1'b0;
                rq.push_back('{due: cyc + 2, src: s, data: ref_mem[a]});
            end
        end
    endtask

    task automatic check_outputs();
        chk("csb0", csb0, e_csb);
        chk("web0", web0, e_web);
        chk("wmask0", wmask0, e_wmask);
        chk("addr0", addr0, e_addr);
        if (e_din_chk) chk("din0", din0, e_din);
        chk("init_done", init_done, m_run);
        if (m_rst_chk) begin
            chk("rsp_rdata_reset", rsp_rdata, '0);
            m_rst_chk = 1'b0;
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, rq[0].src ? 2'b10 : 2'b01);
            chk("rsp_rdata", rsp_rdata, rq[0].data);
            last_rdata = rsp_rdata;
            void'(rq.pop_front());
        end else begin
            chk("rsp_valid_idle", rsp_valid, 2'b00);
        end
    endtask

    task automatic cycle();
        logic [1:0] er;
        #1;
        er = model_ready();
        if (m_known) chk("req_ready", req_ready, er);
        @(posedge clk0);
        model_edge(er);
        @(negedge clk0);
        check_outputs();
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                           input logic [NM-1:0] m, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_we[i]           = we;
        req_addr[i*AW +: AW] = a;
        req_wmask[i*NM +: NM] = m;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle_reqs();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic random_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 2; i++)
                set_req(i, ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), NM'($urandom), DW'($urandom));
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_reqs();
        repeat (3) cycle();

        // Zero-fill; requests pending throughout must not be accepted.
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h01, '0, '0);
        set_req(1, 1'b1, 1'b1, 8'h02, 4'hF, 32'hFFFF_FFFF);
        repeat (DEPTH) cycle();
        chk("init_done_after_fill", init_done, 1'b1);

        // Both requesters reading for 10 cycles: strict alternation.
        set_req(0, 1'b1, 1'b0, 8'h01, '0, '0);
        set_req(1, 1'b1, 1'b0, 8'h02, '0, '0);
        repeat (10) cycle();
`ifdef SRAM_ARB_PERF_EN
        chk("grant_cnt0", grant_cnt0, 16'd5);
        chk("grant_cnt1", grant_cnt1, 16'd5);
        chk("conflict_cnt", conflict_cnt, 16'd10);
`endif
        idle_reqs();
        repeat (3) cycle();

        // Read of a cleared word.
        set_req(0, 1'b1, 1'b0, 8'h55, '0, '0);
        cycle();
        idle_reqs();
        repeat (3) cycle();
        chk("rd_0x55", last_rdata, 32'h0);

        // Masked write then read-after-write from the same requester.
        set_req(0, 1'b1, 1'b1, 8'h10, 4'b0101, 32'hDEAD_BEEF);
        cycle();
        set_req(0, 1'b1, 1'b0, 8'h10, '0, '0);
        cycle();
        idle_reqs();
        repeat (3) cycle();
        chk("rd_0x10", last_rdata, 32'h00AD_00EF);

        random_traffic(500);

        // Reset with reads in flight: responses are dropped, fill restarts.
        set_req(0, 1'b1, 1'b0, 8'h03, '0, '0);
        set_req(1, 1'b1, 1'b0, 8'h04, '0, '0);
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;

        // Reset again in the middle of the fill, once address 100 is presented.
        for (int k = 0; k < DEPTH && m_init_idx != 101; k++) cycle();
        chk("fill_reached_100", addr0, 8'd100);
        rst_n = 1'b0;
        cycle();
        chk("addr0_after_reset", addr0, 8'd0);
        rst_n = 1'b1;
        repeat (DEPTH) cycle();
        chk("init_done_after_refill", init_done, 1'b1);

        random_traffic(300);
        idle_reqs();
        repeat (4) cycle();
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
`ifdef SRAM_ARB_PERF_EN
        chk("grant_cnt0_end", grant_cnt0, 16'(m_g0));
        chk("grant_cnt1_end", grant_cnt1, 16'(m_g1));
        chk("conflict_cnt_end", conflict_cnt, 16'(m_conf));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
